// File: rtl/cordic_iter_down_ctrl_pkg.sv
// Shared CORDIC control definitions: FSM state encoding and default iteration width.
package cordic_iter_down_ctrl_pkg;

    localparam int unsigned CORDIC_ITER_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/cordic_iter_down_ctrl.sv
// Loadable down-counting iteration sequencer: q indexes the CORDIC shift/ROM stage,
// iter_tick advances the datapath, done/ack hands the finished run to the consumer.
module cordic_iter_down_ctrl
    import cordic_iter_down_ctrl_pkg::*;
#(
    parameter int unsigned     W        = CORDIC_ITER_W,
    parameter logic [W-1:0]    STOP_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] load_val,
    input  logic         enable,
    input  logic         ack,
    input  logic         abort,
    output logic [W-1:0] q,
    output logic         busy,
    output logic         done,
    output logic         iter_tick,
    output logic         last,
    output logic         min_tick
);

    state_t       state, state_nx;
    logic [W-1:0] q_nx;
    logic         busy_nx, done_nx;
    logic [W-1:0] load_clamped;

    // A load below the terminal count would never reach it counting down.
    assign load_clamped = (load_val < STOP_VAL) ? STOP_VAL : load_val;

    // NOTE: every next-state variable gets a hold default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        q_nx     = q;
        busy_nx  = busy;
        done_nx  = done;

        if (abort) begin
            state_nx = ST_IDLE;
            q_nx     = '0;
            busy_nx  = 1'b0;
            done_nx  = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_nx = ST_RUN;
                        q_nx     = load_clamped;
                        busy_nx  = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (enable) begin
                        if (q == STOP_VAL) begin
                            state_nx = ST_DONE;
                            busy_nx  = 1'b0;
                            done_nx  = 1'b1;
                        end else begin
                            q_nx = q - 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (ack) begin
                        done_nx = 1'b0;
                        if (start) begin
                            state_nx = ST_RUN;
                            q_nx     = load_clamped;
                            busy_nx  = 1'b1;
                        end else begin
                            state_nx = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    q_nx     = '0;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b0;
                end
            endcase
        end
    end

    // NOTE: registered state uses non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            q     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            q     <= q_nx;
            busy  <= busy_nx;
            done  <= done_nx;
        end
    end

    assign iter_tick = (state == ST_RUN) && enable;
    assign last      = (state == ST_RUN) && (q == STOP_VAL);
    assign min_tick  = (q == '0);

endmodule
